serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit binary adder: accepts operand pair a/b via valid/ready, adds LSB-first one bit
//  per clock through a gate-level full adder, then presents {carry,sum} via valid/ready.
//  Sits downstream of the gate primitives (not_impl, and/or/xor) and upstream of result consumers.
//  Trades area for latency: one full adder plus shift registers instead of a WIDTH-wide ripple chain.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 1..64
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      synchronous, active-low reset (sampled on posedge clk)
//  in_valid   in   1      operand pair a/b valid
//  in_ready   out  1      block can accept an operand pair (high only in IDLE)
//  a          in   WIDTH  operand A, sampled only on accept
//  b          in   WIDTH  operand B, sampled only on accept
//  out_valid  out  1      sum/carry valid
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  (a+b) mod 2^WIDTH, registered
//  carry      out  1      carry out of bit WIDTH-1, registered
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, cnt=0, out_valid=0, sum=0, carry=0; in_ready=1 next cycle.
//    Reset mid-RUN/DONE aborts the operation; no result is produced.
//  - FSM IDLE->RUN->DONE->IDLE. in_ready = (state==IDLE); out_valid = (state==DONE), both decoded from state.
//  - IDLE: on in_valid&&in_ready: load a_sh<=a, b_sh<=b, c<=0, cnt<=0, go RUN. in_valid ignored elsewhere.
//  - RUN, each cycle: {co,s}=full_adder(a_sh[0],b_sh[0],c); a_sh,b_sh shift right 1;
//    s_sh<={s,s_sh[WIDTH-1:1]}; c<=co; cnt<=cnt+1. When cnt==WIDTH-1: sum<=final s_sh, carry<=co, go DONE.
//  - Latency: accept at edge k -> out_valid=1 after edge k+WIDTH. WIDTH=1: RUN lasts exactly one cycle.
//  - DONE: sum/carry held stable while out_valid&&!out_ready (indefinite backpressure legal).
//    On out_ready: go IDLE. Accept never overlaps DONE; min period per op = WIDTH+2 cycles.
//  - sum/carry change only on RUN->DONE transition and reset; otherwise hold last result.
//  - cnt width $clog2(WIDTH)+1; never wraps (cleared on accept).
//  - Arithmetic is unsigned; overflow reported only via carry.
// STRUCTURE
//  - add_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t; shared by bench for probing.
//  - Sub-module full_adder (a, b, ci -> s, co), purely combinational, built from existing gate modules;
//    instantiated once. Everything else (FSM, counter, shift registers) in serial_adder.
// TESTING
//  1. WIDTH=8, a=8'h03,b=8'h05 -> sum=8'h08, carry=0; out_valid rises exactly 8 edges after accept.
//  2. a=8'hFF,b=8'h01 -> sum=8'h00, carry=1 (full carry ripple through all bits).
//  3. a=8'hFF,b=8'hFF -> sum=8'hFE, carry=1; then a=0,b=0 -> sum=0, carry=0 (no stale carry).
//  4. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1, new a/b -> out_valid stays 1, sum/carry
//     unchanged, in_ready=0, new operands not taken; out_ready=1 -> IDLE, in_ready=1 next cycle.
//  5. rst_n=0 on 3rd RUN cycle -> next cycle out_valid=0, sum=0, carry=0, in_ready=1; following op
//     a=8'h10,b=8'h20 -> sum=8'h30, carry=0.
//  6. WIDTH=4 exhaustive: all 256 a/b pairs with random in_valid/out_ready gaps -> {carry,sum}===a+b
//     every time; assertion failure calls $fatal.

Source files
------------

// File: rtl/add_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding used by the RTL
// and by the bench when probing internal state.
package add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } add_state_t;

   // Counter width for a WIDTH-bit operand; one spare bit so it never wraps.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder expressed as XOR/AND/OR gate structure; purely combinational.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic w_axb;
   logic w_ab;
   logic w_cxab;

   assign w_axb  = a ^ b;
   assign w_ab   = a & b;
   assign w_cxab = ci & w_axb;
   assign s      = w_axb ^ ci;
   assign co     = w_ab | w_cxab;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands accepted via valid/ready, summed LSB-first
// one bit per clock through a single full adder, result offered via valid/ready.
module serial_adder
   import add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   add_state_t       r_state;
   add_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_s_sh;
   logic             r_c;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;

   logic             w_s;
   logic             w_co;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH:0]   w_s_cat;
   logic [WIDTH-1:0] w_s_sh_nxt;

   full_adder u_fa (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .ci (r_c),
      .s  (w_s),
      .co (w_co)
   );

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = (r_state == DONE);
   assign w_accept   = in_valid && in_ready;
   assign w_last     = (r_cnt == LAST_CNT);
   // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
   assign w_s_cat    = {w_s, r_s_sh};
   assign w_s_sh_nxt = w_s_cat[WIDTH:1];
   assign sum        = r_sum;
   assign carry      = r_carry;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt <= '0;
         end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == RUN && w_last) begin
            r_sum   <= w_s_sh_nxt;
            r_carry <= w_co;
         end
      end
   end

   // Datapath shift registers are fully (re)loaded on accept, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a_sh <= a;
         r_b_sh <= b;
         r_c    <= 1'b0;
      end else if (r_state == RUN) begin
         r_a_sh <= r_a_sh >> 1;
         r_b_sh <= r_b_sh >> 1;
         r_s_sh <= w_s_sh_nxt;
         r_c    <= w_co;
      end
   end

endmodule
